// File: rtl/nonce_sched_if.sv
// Word-request / digest bus between the nonce scheduler and a sha256d core.
// The scheduler side is the master: it launches hashes and answers word requests.
interface nonce_sched_if;
  logic         sha_start;
  logic [4:0]   sha_addr;
  logic         sha_rq;
  logic         sha_rdy;
  logic [31:0]  sha_data;
  logic [255:0] sha_hash;
  logic         sha_done;

  modport master (
    output sha_start, sha_rdy, sha_data,
    input  sha_addr, sha_rq, sha_hash, sha_done
  );

  modport slave (
    input  sha_start, sha_rdy, sha_data,
    output sha_addr, sha_rq, sha_hash, sha_done
  );
endinterface

// File: rtl/nonce_sched.sv
// Nonce scheduler: walks a nonce range through an external sha256d core,
// serves the block header words to the core and stops on the first digest
// whose little-endian value is at or below the configured target.
module nonce_sched (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [4:0]     cfg_addr,
  input  logic [31:0]    cfg_wdata,
  input  logic [31:0]    nonce_end,
  input  logic           go,
  input  logic           stop,
  input  logic           ack,
  nonce_sched_if.master  sha,
  output logic           busy,
  output logic           found,
  output logic           exhausted,
  output logic [31:0]    found_nonce,
  output logic [255:0]   found_hash
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  state_t        state;
  logic [31:0]   header [0:18];
  logic [31:0]   nonce;
  logic [255:0]  target;
  logic [255:0]  digest;
  logic          stop_pend;
  logic [31:0]   word_sel;
  logic [2:0]    tgt_word;
  logic          hit;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] v);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = v[255-8*i -: 8];
    end
    return r;
  endfunction

  // Addresses 20..27 map to target words 7..0 (20 is the most significant);
  // modulo 8 that is simply 3 minus the low three address bits.
  assign tgt_word = 3'd3 - cfg_addr[2:0];

  // The core delivers the digest big-endian; the target compares against it little-endian.
  assign hit = (bswap256(digest) <= target);

  // Word the core is asking for: header, byte-swapped nonce, or zero padding.
  always_comb begin
    word_sel = '0;
    if (sha.sha_addr < 5'd19) begin
      word_sel = header[sha.sha_addr];
    end else if (sha.sha_addr == 5'd19) begin
      word_sel = bswap32(nonce);
    end
  end

  // Header and target registers accept writes only while the scheduler is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 19; i++) begin
        header[i] <= '0;
      end
      target <= '0;
    end else if (cfg_we && state == S_IDLE) begin
      if (cfg_addr < 5'd19) begin
        header[cfg_addr] <= cfg_wdata;
      end else if (cfg_addr >= 5'd20 && cfg_addr <= 5'd27) begin
        target[{tgt_word, 5'b00000} +: 32] <= cfg_wdata;
      end
    end
  end

  // Word-request responder: one cycle behind the request, held while it stays up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sha.sha_rdy  <= 1'b0;
      sha.sha_data <= '0;
    end else begin
      sha.sha_rdy <= sha.sha_rq;
      if (sha.sha_rq) begin
        sha.sha_data <= word_sel;
      end
    end
  end

  // Search sequencer with registered status outputs and the nonce counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sha.sha_start <= 1'b0;
      busy          <= 1'b0;
      found         <= 1'b0;
      exhausted     <= 1'b0;
      nonce         <= '0;
      digest        <= '0;
      found_nonce   <= '0;
      found_hash    <= '0;
      stop_pend     <= 1'b0;
    end else begin
      sha.sha_start <= 1'b0;
      if (stop && (state == S_LAUNCH || state == S_WAIT || state == S_CHECK)) begin
        stop_pend <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          stop_pend <= 1'b0;
          if (cfg_we && cfg_addr == 5'd19) begin
            nonce <= cfg_wdata;
          end
          if (go) begin
            state         <= S_LAUNCH;
            sha.sha_start <= 1'b1;
            busy          <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (sha.sha_done) begin
            digest <= sha.sha_hash;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            state       <= S_FOUND;
            found       <= 1'b1;
            busy        <= 1'b0;
            found_nonce <= nonce;
            found_hash  <= digest;
          end else if (nonce == nonce_end) begin
            state     <= S_EXHAUSTED;
            exhausted <= 1'b1;
            busy      <= 1'b0;
          end else if (stop_pend) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            stop_pend <= 1'b0;
          end else begin
            nonce         <= nonce + 32'd1;
            state         <= S_LAUNCH;
            sha.sha_start <= 1'b1;
          end
        end
        S_FOUND: begin
          if (ack) begin
            state     <= S_IDLE;
            found     <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
        S_EXHAUSTED: begin
          if (ack) begin
            state     <= S_IDLE;
            exhausted <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          found     <= 1'b0;
          exhausted <= 1'b0;
          stop_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sched.sv
// Directed testbench for nonce_sched: plays the sha256d core on the bus
// interface and checks each scenario against hand-computed values.
module tb_nonce_sched;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [4:0]    cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic [31:0]   nonce_end = '0;
  logic          go = 1'b0;
  logic          stop = 1'b0;
  logic          ack = 1'b0;
  logic          busy;
  logic          found;
  logic          exhausted;
  logic [31:0]   found_nonce;
  logic [255:0]  found_hash;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  localparam logic [255:0] H_ANY   = 256'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_CAFEF00D;
  localparam logic [255:0] H_MISS  = 256'h1;
  localparam logic [255:0] T_EDGE  = 256'h00000000_00000000_00112233_44556677_8899AABB_CCDDEEFF_01020304_05060708;
  localparam logic [255:0] H_EXACT = 256'h08070605_04030201_FFEEDDCC_BBAA9988_77665544_33221100_00000000_00000000;

  nonce_sched_if bus ();

  nonce_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .nonce_end   (nonce_end),
    .go          (go),
    .stop        (stop),
    .ack         (ack),
    .sha         (bus),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .found_nonce (found_nonce),
    .found_hash  (found_hash)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count launch pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.sha_start === 1'b1) start_cnt++;
  end

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_go;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pulse_ack;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.sha_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Core model for one hash: wait for launch, fetch word 19, return a digest.
  task automatic run_hash(input logic [31:0] exp_word, input logic [255:0] h, input string tag);
    bit ok;
    wait_start(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL %s_start: got no sha_start, exp pulse within 20 cycles", tag); end
    @(negedge clk);
    bus.sha_addr = 5'd19; bus.sha_rq = 1'b1;
    @(negedge clk);
    bus.sha_rq = 1'b0;
    checks++;
    if (bus.sha_rdy !== 1'b1 || bus.sha_data !== exp_word) begin
      errors++; $display("[TB] FAIL %s_word19: got rdy=%0b data=%h, exp rdy=1 data=%h", tag, bus.sha_rdy, bus.sha_data, exp_word);
    end
    bus.sha_hash = h; bus.sha_done = 1'b1;
    @(negedge clk);
    bus.sha_done = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, found, exhausted, bus.sha_start, bus.sha_rdy} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b, exp 00000", {busy, found, exhausted, bus.sha_start, bus.sha_rdy});
    end
    checks++;
    if (bus.sha_data !== 32'h0 || found_nonce !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_words: got data=%h nonce=%h, exp 0 0", bus.sha_data, found_nonce);
    end
    checks++;
    if (found_hash !== 256'h0) begin errors++; $display("[TB] FAIL reset_hash: got %h, exp 0", found_hash); end
    bus.sha_rq = 1'b1; bus.sha_addr = 5'd0;
    @(negedge clk);
    checks++;
    if (bus.sha_rdy !== 1'b1 || bus.sha_data !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_hdr0: got rdy=%0b data=%h, exp 1 0", bus.sha_rdy, bus.sha_data);
    end
    bus.sha_addr = 5'd19;
    @(negedge clk);
    checks++;
    if (bus.sha_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_nonce: got %h, exp 0", bus.sha_data); end
    bus.sha_rq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_config_bus;
    for (int i = 0; i < 19; i++) cfg_write(5'(i), {8'hA5, 8'(i), 8'h5A, 8'(i)});
    cfg_write(5'd19, 32'h0000_0005);
    for (int i = 0; i < 8; i++) cfg_write(5'(20 + i), 32'hFFFF_FFFF);
    nonce_end = 32'h0000_0007;
    checks++;
    if (bus.sha_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bus_idle_rdy: got %0b, exp 0", bus.sha_rdy); end
    bus.sha_rq = 1'b1; bus.sha_addr = 5'd3;
    @(negedge clk);
    checks++;
    if (bus.sha_rdy !== 1'b1 || bus.sha_data !== 32'hA503_5A03) begin
      errors++; $display("[TB] FAIL bus_addr3: got rdy=%0b data=%h, exp 1 a5035a03", bus.sha_rdy, bus.sha_data);
    end
    bus.sha_addr = 5'd7;
    @(negedge clk);
    checks++;
    if (bus.sha_rdy !== 1'b1 || bus.sha_data !== 32'hA507_5A07) begin
      errors++; $display("[TB] FAIL bus_addr7: got rdy=%0b data=%h, exp 1 a5075a07", bus.sha_rdy, bus.sha_data);
    end
    bus.sha_addr = 5'd19;
    @(negedge clk);
    checks++;
    if (bus.sha_rdy !== 1'b1 || bus.sha_data !== 32'h0500_0000) begin
      errors++; $display("[TB] FAIL bus_addr19: got rdy=%0b data=%h, exp 1 05000000", bus.sha_rdy, bus.sha_data);
    end
    bus.sha_addr = 5'd22;
    @(negedge clk);
    checks++;
    if (bus.sha_rdy !== 1'b1 || bus.sha_data !== 32'h0) begin
      errors++; $display("[TB] FAIL bus_addr22: got rdy=%0b data=%h, exp 1 0", bus.sha_rdy, bus.sha_data);
    end
    bus.sha_rq = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.sha_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bus_rdy_drop: got %0b, exp 0", bus.sha_rdy); end
  endtask

  task automatic test_single_hit;
    start_cnt = 0;
    pulse_go;
    run_hash(32'h0500_0000, H_ANY, "hit");
    @(negedge clk);
    checks++;
    if (found !== 1'b1 || busy !== 1'b0 || exhausted !== 1'b0) begin
      errors++; $display("[TB] FAIL hit_flags: got found=%0b busy=%0b exh=%0b, exp 1 0 0", found, busy, exhausted);
    end
    checks++;
    if (found_nonce !== 32'h5) begin errors++; $display("[TB] FAIL hit_nonce: got %h, exp 00000005", found_nonce); end
    checks++;
    if (found_hash !== H_ANY) begin errors++; $display("[TB] FAIL hit_hash: got %h, exp %h", found_hash, H_ANY); end
    pulse_go;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt !== 1 || found !== 1'b1) begin
      errors++; $display("[TB] FAIL hit_go_ignored: got starts=%0d found=%0b, exp 1 1", start_cnt, found);
    end
    pulse_ack;
    checks++;
    if (found !== 1'b0 || found_nonce !== 32'h5) begin
      errors++; $display("[TB] FAIL hit_ack: got found=%0b nonce=%h, exp 0 00000005", found, found_nonce);
    end
  endtask

  task automatic test_wrap_exhaust;
    for (int i = 0; i < 8; i++) cfg_write(5'(20 + i), 32'h0);
    cfg_write(5'd19, 32'hFFFF_FFFE);
    nonce_end = 32'h0000_0001;
    start_cnt = 0;
    pulse_go;
    run_hash(32'hFEFF_FFFF, H_MISS, "wrap0");
    run_hash(32'hFFFF_FFFF, H_MISS, "wrap1");
    run_hash(32'h0000_0000, H_MISS, "wrap2");
    run_hash(32'h0100_0000, H_MISS, "wrap3");
    @(negedge clk);
    checks++;
    if (exhausted !== 1'b1 || busy !== 1'b0 || found !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_flags: got exh=%0b busy=%0b found=%0b, exp 1 0 0", exhausted, busy, found);
    end
    checks++;
    if (start_cnt !== 4) begin errors++; $display("[TB] FAIL wrap_starts: got %0d, exp 4", start_cnt); end
    pulse_ack;
    checks++;
    if (exhausted !== 1'b0) begin errors++; $display("[TB] FAIL wrap_ack: got %0b, exp 0", exhausted); end
  endtask

  task automatic test_stop;
    bit ok;
    cfg_write(5'd19, 32'h0000_000A);
    nonce_end = 32'h0000_0014;
    start_cnt = 0;
    pulse_go;
    wait_start(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL stop_start: got no sha_start, exp pulse"); end
    @(negedge clk);
    stop = 1'b1; cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = 32'hFFFF_FFFF;
    bus.sha_rq = 1'b1; bus.sha_addr = 5'd19;
    @(negedge clk);
    stop = 1'b0; cfg_we = 1'b0; bus.sha_rq = 1'b0;
    checks++;
    if (bus.sha_data !== 32'h0A00_0000) begin errors++; $display("[TB] FAIL stop_word19: got %h, exp 0a000000", bus.sha_data); end
    bus.sha_hash = H_MISS; bus.sha_done = 1'b1;
    @(negedge clk);
    bus.sha_done = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0) begin
      errors++; $display("[TB] FAIL stop_idle: got busy=%0b found=%0b exh=%0b, exp 0 0 0", busy, found, exhausted);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (start_cnt !== 1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL stop_no_more: got starts=%0d busy=%0b, exp 1 0", start_cnt, busy);
    end
    bus.sha_rq = 1'b1; bus.sha_addr = 5'd19;
    @(negedge clk);
    checks++;
    if (bus.sha_data !== 32'h0A00_0000) begin errors++; $display("[TB] FAIL stop_nonce_kept: got %h, exp 0a000000", bus.sha_data); end
    bus.sha_addr = 5'd3;
    @(negedge clk);
    bus.sha_rq = 1'b0;
    checks++;
    if (bus.sha_data !== 32'hA503_5A03) begin errors++; $display("[TB] FAIL stop_hdr_kept: got %h, exp a5035a03", bus.sha_data); end
    checks++;
    if (found_nonce !== 32'h5) begin errors++; $display("[TB] FAIL stop_found_held: got %h, exp 00000005", found_nonce); end
    @(negedge clk);
  endtask

  task automatic test_compare_edge;
    logic [255:0] t;
    t = T_EDGE;
    for (int i = 0; i < 8; i++) cfg_write(5'(20 + i), t[255 - 32*i -: 32]);
    cfg_write(5'd19, 32'h0000_0100);
    nonce_end = 32'h0000_0100;
    pulse_go;
    run_hash(32'h0001_0000, H_EXACT, "eq");
    @(negedge clk);
    checks++;
    if (found !== 1'b1 || exhausted !== 1'b0) begin
      errors++; $display("[TB] FAIL eq_hit: got found=%0b exh=%0b, exp 1 0", found, exhausted);
    end
    checks++;
    if (found_nonce !== 32'h100 || found_hash !== H_EXACT) begin
      errors++; $display("[TB] FAIL eq_capture: got nonce=%h hash=%h, exp 00000100 %h", found_nonce, found_hash, H_EXACT);
    end
    pulse_ack;
    cfg_write(5'd27, 32'h0506_0707);
    start_cnt = 0;
    pulse_go;
    run_hash(32'h0001_0000, H_EXACT, "lt");
    @(negedge clk);
    checks++;
    if (found !== 1'b0 || exhausted !== 1'b1) begin
      errors++; $display("[TB] FAIL lt_miss: got found=%0b exh=%0b, exp 0 1", found, exhausted);
    end
    checks++;
    if (start_cnt !== 1) begin errors++; $display("[TB] FAIL lt_one_hash: got %0d, exp 1", start_cnt); end
    pulse_ack;
  endtask

  task automatic test_reset_mid;
    bit ok;
    cfg_write(5'd19, 32'h0000_0000);
    nonce_end = 32'h0000_0009;
    pulse_go;
    wait_start(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rmid_start: got no sha_start, exp pulse"); end
    @(negedge clk);
    bus.sha_rq = 1'b1; bus.sha_addr = 5'd3;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, found, exhausted, bus.sha_start, bus.sha_rdy} !== 5'b0) begin
      errors++; $display("[TB] FAIL rmid_flags: got %b, exp 00000", {busy, found, exhausted, bus.sha_start, bus.sha_rdy});
    end
    checks++;
    if (bus.sha_data !== 32'h0 || found_nonce !== 32'h0 || found_hash !== 256'h0) begin
      errors++; $display("[TB] FAIL rmid_words: got data=%h nonce=%h hash=%h, exp 0", bus.sha_data, found_nonce, found_hash);
    end
    bus.sha_rq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_cnt = 0;
    repeat (10) @(negedge clk);
    checks++;
    if (start_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL rmid_abandon: got starts=%0d busy=%0b, exp 0 0", start_cnt, busy);
    end
    bus.sha_rq = 1'b1; bus.sha_addr = 5'd3;
    @(negedge clk);
    bus.sha_rq = 1'b0;
    checks++;
    if (bus.sha_data !== 32'h0) begin errors++; $display("[TB] FAIL rmid_hdr_clear: got %h, exp 0", bus.sha_data); end
  endtask

  // Scenario sequence and summary.
  initial begin
    bus.sha_addr = '0; bus.sha_rq = 1'b0; bus.sha_hash = '0; bus.sha_done = 1'b0;
    test_reset;
    test_config_bus;
    test_single_hit;
    test_wrap_exhaust;
    test_stop;
    test_compare_edge;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck scenario still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500000, exp finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/nonce_sched.md
NONCE_SCHED -- requirements
Module: nonce_sched

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  config write strobe
- cfg_addr  in  5  config word index: 0..18 header words, 19 start nonce, 20..27 target words (20 = MS word)
- cfg_wdata  in  32  config write data
- nonce_end  in  32  last nonce to try, inclusive
- go  in  1  start search, pulse
- stop  in  1  abort request, pulse
- ack  in  1  acknowledge terminal status, pulse
- sha_start  out  1  start pulse to sha256d core
- sha_addr  in  5  core word request address (0..19 used)
- sha_rq  in  1  core word request
- sha_rdy  out  1  word valid to core
- sha_data  out  32  word to core
- sha_hash  in  256  core digest (word 0 in bits 255:224)
- sha_done  in  1  one-cycle core completion pulse
- busy  out  1  search in progress
- found  out  1  hash <= target found
- exhausted  out  1  range finished, nothing found
- found_nonce  out  32  winning nonce
- found_hash  out  256  winning digest as received from the core

Function
REQ-002 The block SHALL hold a 19x32 header file, a 32-bit nonce counter and a 256-bit target, written only when cfg_we=1 and state=IDLE; writes in any other state and to cfg_addr 28..31 SHALL be ignored.
REQ-003 The state machine SHALL have states IDLE, LAUNCH, WAIT, CHECK, FOUND, EXHAUSTED, with transitions:
- IDLE -> LAUNCH on go
- LAUNCH -> WAIT after one cycle with sha_start=1
- WAIT -> CHECK on sha_done
- CHECK -> FOUND on hit
- CHECK -> EXHAUSTED on miss with nonce == nonce_end
- CHECK -> IDLE on miss with stop pending
- CHECK -> LAUNCH otherwise, nonce incremented
- FOUND/EXHAUSTED -> IDLE on ack
REQ-004 sha_start SHALL be high exactly in LAUNCH, one cycle per hash.
REQ-005 Bus response: when sha_rq is sampled high, sha_rdy SHALL be 1 the next cycle with sha_data = word(sha_addr sampled); sha_rdy SHALL stay 1 while sha_rq stays high and SHALL drop the cycle after sha_rq is sampled low.
REQ-006 word(a) SHALL be header[a] for a in 0..18, byte-swapped nonce counter for a=19, and 0 for a >= 20.
REQ-007 Hit condition: the 256-bit value formed by byte-reversing sha_hash, compared unsigned, SHALL be <= target; the comparison SHALL be evaluated in CHECK on the digest captured at sha_done.
REQ-008 On hit, found_nonce SHALL capture the current nonce counter and found_hash SHALL capture the digest; found=1 while in FOUND.
REQ-009 Nonce increment SHALL be modulo 2^32; when nonce_end is below the start nonce, the search SHALL wrap through 0xFFFFFFFF to 0.
REQ-010 If the start nonce equals nonce_end, exactly one hash SHALL be performed.
REQ-011 stop SHALL be latched in LAUNCH, WAIT or CHECK and take effect at the next CHECK, with hit and exhaust taking priority over stop; stop in IDLE, FOUND or EXHAUSTED SHALL be ignored; the latch SHALL clear on entry to IDLE.
REQ-012 go outside IDLE SHALL be ignored, and ack outside FOUND/EXHAUSTED SHALL be ignored.
REQ-013 busy SHALL be 1 in LAUNCH, WAIT and CHECK, and exhausted=1 in EXHAUSTED.
REQ-014 On return to IDLE, the nonce counter SHALL retain its last value; found_nonce and found_hash SHALL hold until the next hit.

Reset
REQ-015 On rst_n low, state SHALL become IDLE; sha_start, sha_rdy, busy, found and exhausted SHALL be 0; sha_data, found_nonce, found_hash, nonce, header and target SHALL be 0; the stop latch SHALL be cleared.
REQ-016 Reset asserted mid-search SHALL abandon the search immediately, with no further sha_start.

Verification
REQ-017 Config header words 0..18, start nonce 0x00000005, nonce_end 0x00000007, target all-ones, then go -> exactly one sha_start; on core request of addr 19, sha_data=0x05000000; found=1, found_nonce=0x00000005.
REQ-018 Target 0, nonce 0xFFFFFFFE, nonce_end 0x00000001 -> 4 sha_start pulses, with addr-19 words 0xFEFFFFFF, 0xFFFFFFFF, 0x00000000, 0x01000000; then exhausted=1 and busy=0.
REQ-019 Core holds sha_rq with addr 3, 7, 19, 22 -> sha_rdy rises 1 cycle after each rq; data is header[3], header[7], byte-swapped nonce, 0; sha_rdy drops 1 cycle after rq drops.
REQ-020 Stop pulsed during WAIT of nonce 10 with miss -> returns to IDLE after that hash; nonce retained as 10, no further sha_start; cfg_we while busy leaves header unchanged.
REQ-021 Digest whose byte-reversed value equals target exactly -> found=1; target minus 1 -> miss. rst_n low during WAIT -> all outputs 0, IDLE.
